// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the single-port word RAM bus.
// It supports a bounded bus lock and tags each read return with the master that issued it.
module bus_arbiter #(
   parameter int unsigned MAX_LOCK = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [29:0] m0_addr,
   input  logic [31:0] m0_data_w,
   input  logic [3:0]  m0_mask_w,
   input  logic        m0_lock,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_data_r,
   input  logic        m1_req,
   input  logic [29:0] m1_addr,
   input  logic [31:0] m1_data_w,
   input  logic [3:0]  m1_mask_w,
   input  logic        m1_lock,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_data_r,
   output logic [29:0] bus_addr,
   input  logic [31:0] bus_data_r,
   output logic [31:0] bus_data_w,
   output logic [3:0]  bus_mask_w
);
   localparam int unsigned AW = 30;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 4;
   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

   logic          last_q, last_d;
   logic          locked_q, locked_d;
   logic          lock_owner_q, lock_owner_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   logic [1:0]    rd_pend_q, rd_pend_d;
   logic [AW-1:0] addr_q, addr_d;

   logic owner_req;
   logic other_req;
   logic cap_hit;
   logic lock_win;
   logic any_gnt;
   logic sel;
   logic sel_lock;

   // Grant selection: an uncapped lock wins first, then round-robin on contention.
   always_comb begin : grant_select
      owner_req = lock_owner_q ? m1_req : m0_req;
      other_req = lock_owner_q ? m0_req : m1_req;
      cap_hit   = other_req && (lock_cnt_q == MAX_CNT);
      lock_win  = locked_q && owner_req && !cap_hit;
      any_gnt   = 1'b0;
      sel       = 1'b0;
      if (!reset) begin
         if (lock_win) begin
            any_gnt = 1'b1;
            sel     = lock_owner_q;
         end else if (m0_req && m1_req) begin
            any_gnt = 1'b1;
            sel     = !last_q;
         end else if (m0_req) begin
            any_gnt = 1'b1;
            sel     = 1'b0;
         end else if (m1_req) begin
            any_gnt = 1'b1;
            sel     = 1'b1;
         end
      end
   end

   assign m0_gnt = any_gnt && !sel;
   assign m1_gnt = any_gnt && sel;

   // Bus mux; when idle, hold the last address and issue a harmless read.
   always_comb begin : bus_mux
      bus_addr   = reset ? AW'(0) : addr_q;
      bus_data_w = DW'(0);
      bus_mask_w = MW'(0);
      sel_lock   = 1'b0;
      if (any_gnt) begin
         if (sel) begin
            bus_addr   = m1_addr;
            bus_data_w = m1_data_w;
            bus_mask_w = m1_mask_w;
            sel_lock   = m1_lock;
         end else begin
            bus_addr   = m0_addr;
            bus_data_w = m0_data_w;
            bus_mask_w = m0_mask_w;
            sel_lock   = m0_lock;
         end
      end
   end

   always_comb begin : next_state
      last_d       = last_q;
      locked_d     = locked_q;
      lock_owner_d = lock_owner_q;
      lock_cnt_d   = lock_cnt_q;
      rd_pend_d    = 2'b00;
      addr_d       = bus_addr;
      if (any_gnt) begin
         last_d         = sel;
         rd_pend_d[sel] = (bus_mask_w == MW'(0));
         if (sel_lock) begin
            locked_d     = 1'b1;
            lock_owner_d = sel;
            if (lock_owner_q == sel) begin
               lock_cnt_d = (lock_cnt_q == MAX_CNT) ? MAX_CNT : lock_cnt_q + CW'(1);
            end else begin
               lock_cnt_d = CW'(1);
            end
         end else begin
            locked_d   = 1'b0;
            lock_cnt_d = CW'(0);
         end
      end else if (locked_q && !owner_req) begin
         locked_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_q       <= 1'b1;
         locked_q     <= 1'b0;
         lock_owner_q <= 1'b0;
         lock_cnt_q   <= CW'(0);
         rd_pend_q    <= 2'b00;
         addr_q       <= AW'(0);
      end else begin
         last_q       <= last_d;
         locked_q     <= locked_d;
         lock_owner_q <= lock_owner_d;
         lock_cnt_q   <= lock_cnt_d;
         rd_pend_q    <= rd_pend_d;
         addr_q       <= addr_d;
      end
   end

   // Read returns are suppressed while reset is held.
   assign m0_rvalid = rd_pend_q[0] && !reset;
   assign m1_rvalid = rd_pend_q[1] && !reset;
   assign m0_data_r = bus_data_r;
   assign m1_data_r = bus_data_r;

endmodule
